// File: rtl/rej_count_fifo.sv
// FIFO of per-packet reject counts; the head entry counts down in place and retires when exhausted.
// Optional REJ_COUNT_FIFO_STATS_EN adds full/occupancy/sticky overflow status ports.
module rej_count_fifo #(
   parameter int COUNT_WIDTH = 8,
   parameter int DEPTH       = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [COUNT_WIDTH-1:0]    rej_count_in,
   input  logic                      shift_in,
   input  logic                      countdown,
   output logic [COUNT_WIDTH-1:0]    head,
   output logic                      head_valid
`ifdef REJ_COUNT_FIFO_STATS_EN
   ,
   output logic                      full,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic                      overflow
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   logic [COUNT_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [OCC_W-1:0]       occ_q;

   logic [COUNT_WIDTH-1:0] cur_head;
   logic                   is_empty;
   logic                   is_full;
   logic                   cd_act;
   logic                   pop;
   logic                   dec;
   logic                   push;

   assign cur_head = mem[rd_ptr];
   assign is_empty = (occ_q == '0);
   assign is_full  = (occ_q == OCC_FULL);
   assign cd_act   = countdown && !is_empty;
   // A head of 0 or 1 retires on this countdown; larger values decrement in place.
   assign pop      = cd_act && (cur_head <= COUNT_WIDTH'(1));
   assign dec      = cd_act && (cur_head > COUNT_WIDTH'(1));
   // A pop at the same edge frees the slot, so a push into a full FIFO still lands.
   assign push     = shift_in && (!is_full || pop);

   assign head       = is_empty ? '0 : cur_head;
   assign head_valid = !is_empty;

   // Push and in-place decrement never hit the same slot: when full, a push implies a pop.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= rej_count_in;
      if (dec)
         mem[rd_ptr] <= cur_head - COUNT_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ_q  <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         if (push && !pop)
            occ_q <= occ_q + OCC_W'(1);
         else if (pop && !push)
            occ_q <= occ_q - OCC_W'(1);
      end
   end

`ifdef REJ_COUNT_FIFO_STATS_EN
   logic overflow_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow_q <= 1'b0;
      else if (shift_in && !push)
         overflow_q <= 1'b1;
   end

   assign full      = is_full;
   assign occupancy = occ_q;
   assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_rej_count_fifo.sv
// Directed bench for rej_count_fifo with hand-computed expectations.
// Status-port checks are compiled in when REJ_COUNT_FIFO_STATS_EN is defined.
module tb_rej_count_fifo;

   logic       clk;
   logic       rst;
   logic [7:0] rej_count_in;
   logic       shift_in;
   logic       countdown;
   logic [7:0] head;
   logic       head_valid;
`ifdef REJ_COUNT_FIFO_STATS_EN
   logic       full;
   logic [4:0] occupancy;
   logic       overflow;
`endif

   int n_cmp;
   int n_bad;

   rej_count_fifo #(.COUNT_WIDTH(8), .DEPTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .rej_count_in (rej_count_in),
      .shift_in     (shift_in),
      .countdown    (countdown),
      .head         (head),
      .head_valid   (head_valid)
`ifdef REJ_COUNT_FIFO_STATS_EN
      ,
      .full         (full),
      .occupancy    (occupancy),
      .overflow     (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input int exp_head, input int exp_valid);
      check({tag, ".head"}, int'(head), exp_head);
      check({tag, ".valid"}, int'(head_valid), exp_valid);
   endtask

   int exp_cd [8];
   int drain [16];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      rej_count_in = '0;
      shift_in = 1'b0;
      countdown = 1'b0;
      tick();
      tick();
      check_head("reset", 0, 0);
`ifdef REJ_COUNT_FIFO_STATS_EN
      check("reset.full", int'(full), 0);
      check("reset.occ", int'(occupancy), 0);
      check("reset.ovf", int'(overflow), 0);
`endif
      rst = 1'b0;
      tick();
      tick();
      check_head("idle", 0, 0);

      // Push 5, idle 5 cycles, push 3.
      rej_count_in = 8'd5;
      shift_in = 1'b1;
      tick();
      shift_in = 1'b0;
      check_head("push5", 5, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_head("hold5", 5, 1);
      end
      rej_count_in = 8'd3;
      shift_in = 1'b1;
      tick();
      shift_in = 1'b0;
      check_head("push3", 5, 1);
`ifdef REJ_COUNT_FIFO_STATS_EN
      check("push3.occ", int'(occupancy), 2);
`endif

      // Held countdown: 5 -> 4,3,2,1, pop -> 3,2,1, pop -> empty.
      exp_cd = '{4, 3, 2, 1, 3, 2, 1, 0};
      countdown = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check_head($sformatf("cd%0d", i), exp_cd[i], (i == 7) ? 0 : 1);
      end
      tick();
      tick();
      check_head("cd_empty", 0, 0);

      // Countdown still held while empty; push 3 lands, then counts down.
      rej_count_in = 8'd3;
      shift_in = 1'b1;
      tick();
      shift_in = 1'b0;
      check_head("emp_push", 3, 1);
      tick();
      check_head("emp_cd1", 2, 1);
      tick();
      check_head("emp_cd2", 1, 1);
      tick();
      check_head("emp_cd3", 0, 0);
      countdown = 1'b0;

      // Zero entry behaves as one.
      rej_count_in = 8'd0;
      shift_in = 1'b1;
      tick();
      check_head("push0", 0, 1);
      rej_count_in = 8'd7;
      tick();
      shift_in = 1'b0;
      check_head("push7", 0, 1);
      countdown = 1'b1;
      tick();
      countdown = 1'b0;
      check_head("zero_pop", 7, 1);

      // Build 3 entries then assert reset asynchronously mid-cycle.
      shift_in = 1'b1;
      rej_count_in = 8'd1;
      tick();
      rej_count_in = 8'd2;
      tick();
      shift_in = 1'b0;
`ifdef REJ_COUNT_FIFO_STATS_EN
      check("pre_rst.occ", int'(occupancy), 3);
`endif
      check_head("pre_rst", 7, 1);
      #2;
      rst = 1'b1;
      #1;
      check_head("async_rst", 0, 0);
`ifdef REJ_COUNT_FIFO_STATS_EN
      check("async_rst.occ", int'(occupancy), 0);
`endif
      #1;
      rst = 1'b0;
      tick();
      check_head("post_rst", 0, 0);

      // Fill with 1..16, then a dropped push of 99.
      shift_in = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         rej_count_in = 8'(i);
         tick();
      end
      check_head("filled", 1, 1);
`ifdef REJ_COUNT_FIFO_STATS_EN
      check("filled.full", int'(full), 1);
      check("filled.occ", int'(occupancy), 16);
      check("filled.ovf", int'(overflow), 0);
`endif
      rej_count_in = 8'd99;
      tick();
      shift_in = 1'b0;
      check_head("drop99", 1, 1);
`ifdef REJ_COUNT_FIFO_STATS_EN
      check("drop99.full", int'(full), 1);
      check("drop99.ovf", int'(overflow), 1);
      check("drop99.occ", int'(occupancy), 16);
`endif

      // Push 42 with pop at the same edge while full.
      rej_count_in = 8'd42;
      shift_in = 1'b1;
      countdown = 1'b1;
      tick();
      shift_in = 1'b0;
      countdown = 1'b0;
      check_head("push_pop", 2, 1);
`ifdef REJ_COUNT_FIFO_STATS_EN
      check("push_pop.occ", int'(occupancy), 16);
      check("push_pop.ovf", int'(overflow), 1);
`endif

      // Drain: each entry of value N retires after N countdown edges.
      drain = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 42};
      countdown = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check_head($sformatf("drain%0d", k), drain[k], 1);
         for (int j = 0; j < drain[k]; j++)
            tick();
      end
      check_head("drained", 0, 0);
      tick();
      countdown = 1'b0;
      check_head("drained_idle", 0, 0);
`ifdef REJ_COUNT_FIFO_STATS_EN
      check("drained.occ", int'(occupancy), 0);
      check("drained.full", int'(full), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/rej_count_fifo.md
Name: rej_count_fifo

Overview:
- Small synchronous FIFO of per-packet reject counts used by the packet filter's accept/reject bookkeeping.
- Producer pushes a count with `shift_in`. Consumer asserts `countdown` once per rejected item.
- The head entry decrements in place and retires when exhausted, exposing the next count.

Parameters:
- COUNT_WIDTH, 8: bit width of each stored count.
- DEPTH, 16: number of FIFO entries; any integer >= 2. Pointers wrap at DEPTH, not at a power of two.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- rej_count_in  in  COUNT_WIDTH  count to enqueue.
- shift_in  in  1  push `rej_count_in` at this clock edge.
- countdown  in  1  consume one unit from the head entry at this edge.
- head  out  COUNT_WIDTH  current (remaining) value of the oldest entry; 0 when empty.
- head_valid  out  1  FIFO non-empty.

Behaviour:
- Storage: DEPTH x COUNT_WIDTH register array, read pointer, write pointer, occupancy counter 0..DEPTH.
- Reset (async, `rst`=1): pointers=0, occupancy=0, so `head_valid`=0 and `head`=0. Array contents are don't-care.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Outputs are combinational from registered state:
  - `head` = mem[rd_ptr] when occupancy>0, else 0.
  - `head_valid` = (occupancy!=0).
- Push: `shift_in`=1 and not full writes mem[wr_ptr] and advances wr_ptr (wrap DEPTH-1 -> 0).
  - When pushing into an empty FIFO, `head`/`head_valid` reflect the new entry the cycle after the edge (1-cycle latency).
- Push when full, with no pop at the same edge: entry dropped, no state change.
- Countdown: `countdown`=1 with `head_valid`=0 is ignored. With `head_valid`=1:
  - head value > 1: mem[rd_ptr] <= head-1, in place.
  - head value <= 1, i.e. 1 or 0: pop, rd_ptr advances.
  - Result: an entry of value N is retired after max(N,1) countdown cycles. A pushed 0 behaves as 1.
- Simultaneous push and pop at the same edge: both take effect and occupancy is unchanged.
  - When full, the pop frees a slot, so the push is accepted.
- Simultaneous push and in-place decrement: independent slots; both take effect.
  - Exception: when empty, the decrement is ignored and the push lands.
- Occupancy arithmetic: +1 on push-only, -1 on pop-only, unchanged otherwise; never exceeds DEPTH or goes below 0.
- Decrement is unsigned COUNT_WIDTH arithmetic; no underflow can occur given the pop rule above.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: REJ_COUNT_FIFO_STATS_EN.
- Defined: adds three output ports.
  - `full` (1): occupancy==DEPTH.
  - `occupancy` ($clog2(DEPTH+1)): live entry count.
  - `overflow` (1): sticky, set on any dropped push; cleared only by `rst`.
  - All three are 0 during and after reset.
- Undefined: ports absent; dropped pushes are silent. Core behaviour is identical in both builds.

Test Plan:
- Reset then idle: `head_valid`=0 and `head`=0. Assert `rst` asynchronously mid-run with 3 entries -> both outputs go to 0 before the next clock edge.
- Push 5, wait 5 cycles, push 3 -> head=5 and head_valid=1 from the cycle after the first push; head stays 5 after the second push.
- Hold `countdown`=1 starting from the previous state:
  - head: 5,4,3,2,1, then 3,2,1, then head_valid=0 and head=0.
  - Exactly 8 countdown cycles consume both entries; further countdown is ignored.
- Countdown held while FIFO is empty, then push 3 -> entry appears as head=3 the next cycle and decrements 3,2,1 on following cycles, then empties.
- Push 0 and 7 back-to-back, then countdown 1 cycle -> 0-entry retired after one countdown; head=7.
- Fill to DEPTH=16 with values 1..16, then push 99 -> dropped; with STATS_EN, `overflow`=1 and `full`=1.
  - Then push 42 with countdown at the same edge (head=1) -> pop and push both occur and occupancy stays 16.
  - Drain order: 2..16, 42.
